clk_rst_seq: RTL
================

// Module: clk_rst_seq
// PURPOSE
//  Parametrised clock/reset sequencer. Sits beside the PLL, clocked by the PLL output clock.
//  - Drives the PLL reset; qualifies PLL lock; releases NCH channel resets in order.
//  - Generates per-channel divided clock-enables and toggle clocks, with runtime divide ratios.
//  - Re-runs the full sequence on lock loss, lock timeout or a soft-reset request.
// PARAMETERS
//  NCH       4     number of output channels (1..8)
//  DW        8     divide-ratio width per channel
//  STRETCH   15    cycles PLL reset is held asserted on every entry to S_RST
//  LOCK_FILT 8     consecutive synchronised-lock cycles required to accept lock
//  LOCK_TO   1000  cycles allowed in S_WAIT before a retry (timeout)
//  SEQ_GAP   4     cycles between successive channel reset releases
// PORTS
//  CLK       in   1       clock (PLL output domain)
//  RSTX      in   1       reset, asynchronous, active-low
//  PLL_LOCK  in   1       PLL lock, asynchronous; 2-flop synchronised internally (lock_s)
//  SOFT_RST  in   1       1-cycle pulse: restart sequence
//  DIV       in   NCH*DW  divide ratio per channel, ch i = DIV[i*DW +: DW]; 0 treated as 1
//  DIV_LD    in   1       1-cycle pulse: capture DIV into shadow registers
//  STAT_CLR  in   1       clears LOCK_LOST and TIMEOUT
//  RSTXP     out  1       PLL reset, active-low
//  RSTXC     out  NCH     per-channel reset, active-low, synchronous to CLK
//  CE        out  NCH     per-channel 1-cycle clock-enable pulse
//  CLKO      out  NCH     per-channel toggle clock; toggles on every CE (period 2*DIV cycles)
//  STATE     out  2       0=S_RST 1=S_WAIT 2=S_SEQ 3=S_RUN
//  LOCK_LOST out  1       sticky: lock dropped in S_SEQ/S_RUN
//  TIMEOUT   out  1       sticky: LOCK_TO expired in S_WAIT
// BEHAVIOUR
//  Reset (RSTX=0): all outputs 0, STATE=S_RST, counters 0, lock sync flops 0, shadow DIV=1.
//  Edge n = nth rising CLK edge after RSTX deasserts. All outputs registered.
//  S_RST:  RSTXP=0; RSTXC=0; count STRETCH cycles, then S_WAIT with RSTXP=1 at that edge.
//  S_WAIT: filter counter +1 per edge with lock_s=1, cleared on lock_s=0.
//    - Filter reaches LOCK_FILT: enter S_SEQ; RSTXC[0]=1 on the same edge.
//    - LOCK_TO cycles spent in S_WAIT: set TIMEOUT and go to S_RST (retry, unbounded).
//  S_SEQ:  RSTXC[i] rises SEQ_GAP cycles after RSTXC[i-1].
//    - The edge that raises RSTXC[NCH-1] also enters S_RUN.
//    - NCH=1: go S_WAIT -> S_RUN directly; RSTXC[0] rises on that edge.
//  S_RUN:  hold until an abort event.
//  Abort (lock_s=0 in S_SEQ/S_RUN, or SOFT_RST in any state):
//    - Next edge: STATE=S_RST, RSTXP=0, all RSTXC=0, CE=0, CLKO=0, divider counters=0.
//    - LOCK_LOST is set only for lock aborts.
//    - SOFT_RST takes priority over all other transitions.
//    - SOFT_RST during S_RST restarts the STRETCH count.
//  Divider per channel:
//    - 0 when RSTXC[i]=0; else counts 0..D-1 and wraps, D = max(shadow DIV[i],1).
//    - CE[i]=1 on the edge the counter wraps; CLKO[i] toggles on that edge.
//    - First CE[i] is D edges after RSTXC[i] rises. D=1 gives CE[i] constantly 1 and CLKO at CLK/2.
//  DIV_LD: DIV captured to a staging register. Each channel adopts the staged value at its next
//    wrap, or at its reset release, so a ratio never changes mid-period.
//  DIV_LD coincident with a wrap: the new value is used from the following period.
//  STAT_CLR: sticky bits clear next edge. STAT_CLR coincident with a set event leaves the bit set.
//  Glitch shorter than 1 CLK cycle on PLL_LOCK may be missed; by design.
// TESTING (NCH=2, STRETCH=15, LOCK_FILT=8, LOCK_TO=1000, SEQ_GAP=4, DIV={3,1})
//  1. PLL_LOCK tied 1, RSTX released.
//     -> RSTXP=1@edge15, RSTXC[0]=1@23, RSTXC[1]=1@27, STATE=3@27.
//     -> CE[0]@26,29,32..; CE[1] every cycle from edge 28.
//  2. PLL_LOCK chatters (1 for 5 cycles, 0 for 1) during S_WAIT.
//     -> no S_SEQ entry; TIMEOUT=1 and STATE=0 at edge 1015.
//  3. In S_RUN, drop PLL_LOCK for 3 cycles.
//     -> RSTXC=0, RSTXP=0, LOCK_LOST=1 by 3 edges after the drop; full resequence follows.
//  4. In S_RUN, DIV_LD with DIV[0]=5 issued mid-period.
//     -> current period completes at 3 cycles; subsequent CE[0] spacing is 5.
//  5. SOFT_RST in S_SEQ between the two releases.
//     -> next edge STATE=0, all RSTXC=0, LOCK_LOST unchanged; resequence timing as test 1.
//  6. STAT_CLR coincident with a lock drop -> LOCK_LOST stays 1.
//     DIV=0 on ch0 -> ch0 behaves exactly as DIV=1.

Source files
------------

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer beside the PLL: holds PLL reset, qualifies lock, releases
// channel resets in order and generates per-channel divided clock enables / toggle clocks.
module clk_rst_seq #(
  parameter int NCH       = 4,
  parameter int DW        = 8,
  parameter int STRETCH   = 15,
  parameter int LOCK_FILT = 8,
  parameter int LOCK_TO   = 1000,
  parameter int SEQ_GAP   = 4
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              PLL_LOCK,
  input  logic              SOFT_RST,
  input  logic [NCH*DW-1:0] DIV,
  input  logic              DIV_LD,
  input  logic              STAT_CLR,
  output logic              RSTXP,
  output logic [NCH-1:0]    RSTXC,
  output logic [NCH-1:0]    CE,
  output logic [NCH-1:0]    CLKO,
  output logic [1:0]        STATE,
  output logic              LOCK_LOST,
  output logic              TIMEOUT
);

  localparam int SW = (STRETCH   > 1) ? $clog2(STRETCH)   : 1;
  localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int TW = (LOCK_TO   > 1) ? $clog2(LOCK_TO)   : 1;
  localparam int GW = (SEQ_GAP   > 1) ? $clog2(SEQ_GAP)   : 1;
  localparam int IW = (NCH       > 1) ? $clog2(NCH)       : 1;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_SEQ  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   str_cnt;
  logic [FW-1:0]   filt_cnt;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   seq_idx;
  logic            lock_m;
  logic            lock_s;
  logic            lock_abort;
  logic            abort;
  logic [NCH*DW-1:0] div_stg;

  assign STATE      = state;
  assign lock_abort = !lock_s && ((state == S_SEQ) || (state == S_RUN));
  assign abort      = SOFT_RST || lock_abort;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= PLL_LOCK;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      for (int i = 0; i < NCH; i++) div_stg[i*DW +: DW] <= DW'(1);
    end else if (DIV_LD) begin
      div_stg <= DIV;
    end
  end

  // Sticky clears are written first so a coinciding set event further down wins.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state     <= S_RST;
      str_cnt   <= '0;
      filt_cnt  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      seq_idx   <= '0;
      RSTXP     <= 1'b0;
      RSTXC     <= '0;
      LOCK_LOST <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      if (STAT_CLR) begin
        LOCK_LOST <= 1'b0;
        TIMEOUT   <= 1'b0;
      end
      if (abort) begin
        state    <= S_RST;
        str_cnt  <= '0;
        filt_cnt <= '0;
        to_cnt   <= '0;
        gap_cnt  <= '0;
        seq_idx  <= '0;
        RSTXP    <= 1'b0;
        RSTXC    <= '0;
        if (lock_abort) LOCK_LOST <= 1'b1;
      end else begin
        case (state)
          S_RST: begin
            if (str_cnt == SW'(STRETCH - 1)) begin
              state    <= S_WAIT;
              RSTXP    <= 1'b1;
              filt_cnt <= '0;
              to_cnt   <= '0;
            end else begin
              str_cnt <= str_cnt + SW'(1);
            end
          end
          S_WAIT: begin
            if (lock_s && (filt_cnt == FW'(LOCK_FILT - 1))) begin
              RSTXC[0] <= 1'b1;
              gap_cnt  <= '0;
              seq_idx  <= IW'(1);
              state    <= (NCH == 1) ? S_RUN : S_SEQ;
            end else if (to_cnt == TW'(LOCK_TO - 1)) begin
              TIMEOUT <= 1'b1;
              state   <= S_RST;
              RSTXP   <= 1'b0;
              str_cnt <= '0;
            end else begin
              filt_cnt <= lock_s ? filt_cnt + FW'(1) : '0;
              to_cnt   <= to_cnt + TW'(1);
            end
          end
          S_SEQ: begin
            if (gap_cnt == GW'(SEQ_GAP - 1)) begin
              RSTXC[seq_idx] <= 1'b1;
              gap_cnt        <= '0;
              seq_idx        <= seq_idx + IW'(1);
              if (seq_idx == IW'(NCH - 1)) state <= S_RUN;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Each divider reloads its ratio only while held in reset or at a wrap,
  // so a period in progress always finishes with the ratio it started with.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] cnt;
    logic [DW-1:0] div_act;
    logic [DW-1:0] d_eff;
    logic          wrap;
    logic          ce_q;
    logic          clko_q;

    assign d_eff   = (div_act == '0) ? DW'(1) : div_act;
    assign wrap    = (cnt == d_eff - DW'(1));
    assign CE[i]   = ce_q;
    assign CLKO[i] = clko_q;

    always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
        cnt     <= '0;
        div_act <= DW'(1);
        ce_q    <= 1'b0;
        clko_q  <= 1'b0;
      end else if (abort || !RSTXC[i]) begin
        cnt     <= '0;
        div_act <= div_stg[i*DW +: DW];
        ce_q    <= 1'b0;
        clko_q  <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        div_act <= div_stg[i*DW +: DW];
        ce_q    <= 1'b1;
        clko_q  <= ~clko_q;
      end else begin
        cnt  <= cnt + DW'(1);
        ce_q <= 1'b0;
      end
    end
  end

endmodule
